// File: rtl/vga_timing_pkg.sv
// Raster timing constants and helpers shared by the scan generator.
// Defaults describe 800x600 at 72 Hz with a 50 MHz pixel rate.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;

    localparam int MAX_H_TOTAL = 2048;
    localparam int MAX_V_TOTAL = 1024;
    localparam int MAX_SYNC_DELAY = 4;

    function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First and last counter value of the sync pulse window.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

    localparam int DEF_H_TOTAL = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = scan_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register, DEPTH stages of W bits, loaded with FILL on reset.
// Latency DEPTH enabled steps (DEPTH=0 is a wire); holds whenever en_i is low.
module sync_delay_line #(
    parameter int           W     = 2,
    parameter int           DEPTH = 1,
    parameter logic [W-1:0] FILL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] d_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, rst, en_i};
            assign d_o = d_i;
        end else begin : g_shift
            logic [W-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= FILL;
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign d_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel coordinates, active flag, delayed syncs, frame strobes.
// Coordinates/active are combinational from the counters; syncs lag by SYNC_DELAY pixel steps.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b1,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        o_active,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > MAX_H_TOTAL || H_TOTAL < 1) begin : g_bad_h
            $error("vga_scan_gen: H_TOTAL out of range for an 11-bit counter");
        end
        if (V_TOTAL > MAX_V_TOTAL || V_TOTAL < 1) begin : g_bad_v
            $error("vga_scan_gen: V_TOTAL out of range for a 10-bit counter");
        end
        if (SYNC_DELAY > MAX_SYNC_DELAY || SYNC_DELAY < 0) begin : g_bad_dly
            $error("vga_scan_gen: SYNC_DELAY must be 0..4");
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(sync_start(H_ACTIVE, H_FP));
    localparam logic [10:0] HS_LAST  = 11'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [9:0]  VS_FIRST = 10'(sync_start(V_ACTIVE, V_FP));
    localparam logic [9:0]  VS_LAST  = 10'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic        run_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        frame_start_q, frame_start_d;
    logic        vblank_start_q, vblank_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    always_comb begin
        hcnt_d         = hcnt_q;
        vcnt_d         = vcnt_q;
        frame_cnt_d    = frame_cnt_q;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;
        if (!run_q) begin
            // Leaving reset lands the raster on (0,0), which starts a frame.
            frame_start_d = 1'b1;
        end else if (pix_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d        = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
                if (vcnt_d == V_ACT) begin
                    vblank_start_d = 1'b1;
                    frame_cnt_d    = frame_cnt_q + 8'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q          <= 1'b0;
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            run_q          <= 1'b1;
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    logic       raw_h, raw_v;
    logic [1:0] sync_raw, sync_dly;

    assign raw_h = run_q && (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
    assign raw_v = run_q && (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
    // Map asserted/deasserted onto the configured pin polarity.
    assign sync_raw = {~(raw_h ^ SYNC_POL), ~(raw_v ^ SYNC_POL)};

    sync_delay_line #(
        .W     (2),
        .DEPTH (SYNC_DELAY),
        .FILL  ({2{~SYNC_POL}})
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .en_i (pix_en),
        .d_i  (sync_raw),
        .d_o  (sync_dly)
    );

    assign x            = hcnt_q;
    assign y            = vcnt_q;
    assign o_active     = run_q && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hsync        = sync_dly[1];
    assign vsync        = sync_dly[0];
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a 15x8 raster with one pixel of sync delay.
module tb_vga_scan_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic [10:0] x;
    logic [9:0]  y;
    logic        o_active, hsync, vsync, frame_start, vblank_start;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    vga_scan_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .SYNC_DELAY(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .x(x), .y(y), .o_active(o_active), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .vblank_start(vblank_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [10:0] x;
        logic [9:0]  y;
        logic        act, hs, vs, fs, vb;
        logic [7:0]  fc;
    } vec_t;

    vec_t tbl [0:19];

    function automatic vec_t v(input int r, input int e, input int vx, input int vy,
                               input int act, input int hs, input int vs,
                               input int fs, input int vb, input int fc);
        vec_t t;
        t.rst_n = r[0]; t.en = e[0]; t.x = 11'(vx); t.y = 10'(vy);
        t.act = act[0]; t.hs = hs[0]; t.vs = vs[0]; t.fs = fs[0]; t.vb = vb[0];
        t.fc = 8'(fc);
        return t;
    endfunction

    function automatic logic [34:0] dut_vec();
        return {x, y, o_active, hsync, vsync, frame_start, vblank_start, frame_cnt};
    endfunction

    task automatic check1(input string name, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Reference raster position and sync pipeline for the 15x8 timing.
    int         mx, my;
    logic       mrun, mh, mv, efs, evb;
    logic [7:0] mfc;

    task automatic step(input logic r, input logic e);
        logic rh, rv;
        rst = r; pix_en = e;
        @(posedge clk); #1;
        efs = 1'b0; evb = 1'b0;
        if (!r) begin
            mx = 0; my = 0; mrun = 1'b0; mh = 1'b0; mv = 1'b0; mfc = 8'd0;
        end else begin
            rh = mrun && mx >= 10 && mx <= 12;
            rv = mrun && my >= 5 && my <= 6;
            if (e) begin mh = rh; mv = rv; end
            if (!mrun) begin
                mrun = 1'b1; efs = 1'b1;
            end else if (e) begin
                if (mx == 14) begin
                    mx = 0;
                    my = (my == 7) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
                efs = (mx == 0 && my == 0);
                evb = (mx == 0 && my == 4);
                if (evb) mfc = mfc + 8'd1;
            end
        end
        check1("step", dut_vec(),
               {11'(mx), 10'(my), mrun && mx < 8 && my < 4, mh, mv, efs, evb, mfc});
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int vs_cycles;
        logic saw_wrap;

        tbl[0]  = v(0,1,  0,0, 0,0,0,0,0, 0);
        tbl[1]  = v(1,1,  0,0, 1,0,0,1,0, 0);
        tbl[2]  = v(1,0,  0,0, 1,0,0,0,0, 0);
        tbl[3]  = v(1,1,  1,0, 1,0,0,0,0, 0);
        tbl[4]  = v(1,1,  2,0, 1,0,0,0,0, 0);
        tbl[5]  = v(1,1,  3,0, 1,0,0,0,0, 0);
        tbl[6]  = v(1,1,  4,0, 1,0,0,0,0, 0);
        tbl[7]  = v(1,1,  5,0, 1,0,0,0,0, 0);
        tbl[8]  = v(1,1,  6,0, 1,0,0,0,0, 0);
        tbl[9]  = v(1,1,  7,0, 1,0,0,0,0, 0);
        tbl[10] = v(1,1,  8,0, 0,0,0,0,0, 0);
        tbl[11] = v(1,1,  9,0, 0,0,0,0,0, 0);
        tbl[12] = v(1,1, 10,0, 0,0,0,0,0, 0);
        tbl[13] = v(1,1, 11,0, 0,1,0,0,0, 0);
        tbl[14] = v(1,0, 11,0, 0,1,0,0,0, 0);
        tbl[15] = v(1,1, 12,0, 0,1,0,0,0, 0);
        tbl[16] = v(1,1, 13,0, 0,1,0,0,0, 0);
        tbl[17] = v(1,1, 14,0, 0,0,0,0,0, 0);
        tbl[18] = v(1,1,  0,1, 1,0,0,0,0, 0);
        tbl[19] = v(1,0,  0,1, 1,0,0,0,0, 0);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst_n; pix_en = tbl[i].en;
            @(posedge clk); #1;
            check1($sformatf("vec%0d", i), dut_vec(),
                   {tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].hs, tbl[i].vs,
                    tbl[i].fs, tbl[i].vb, tbl[i].fc});
        end

        mx = 0; my = 1; mrun = 1'b1; mh = 1'b0; mv = 1'b0; mfc = 8'd0;

        // Rest of the first frame up to the wrap back to (0,0).
        vs_cycles = 0;
        for (int i = 0; i < 200 && !(mx == 0 && my == 0); i++) begin
            step(1'b1, 1'b1);
            if (vsync) vs_cycles++;
        end
        check1("fs_at_wrap", {34'd0, frame_start}, 35'd1);
        check1("fc_after_frame", {27'd0, frame_cnt}, 35'd1);
        check1("vsync_cycles", 35'(vs_cycles), 35'd30);

        // Half-rate pixel enable for two frames' worth of clocks.
        for (int i = 0; i < 240; i++) step(1'b1, (i % 2) == 1);

        // Run until frame_cnt wraps 255 -> 0.
        saw_wrap = 1'b0;
        for (int i = 0; i < 40000 && !saw_wrap; i++) begin
            step(1'b1, 1'b1);
            if (evb && mfc == 8'd0) saw_wrap = 1'b1;
        end
        check1("vb_at_wrap", {34'd0, vblank_start}, 35'd1);
        check1("fc_wrap", {27'd0, frame_cnt}, 35'd0);

        // Reset asserted mid-frame at (6,2).
        for (int i = 0; i < 200 && !(mx == 6 && my == 2); i++) step(1'b1, 1'b1);
        check1("at_6_2", {14'd0, x, y}, {14'd0, 11'd6, 10'd2});
        step(1'b0, 1'b1);
        check1("rst_mid", dut_vec(), 35'd0);
        step(1'b1, 1'b1);
        check1("fs_after_rst", {34'd0, frame_start}, 35'd1);
        step(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
